// File: rtl/systolic_skew_feeder.sv
// Edge feeder for the systolic MAC array: accepts one k-step per beat, skews row i / column j
// by i / j cycles, and frames each tile with a counter-sync pulse and a drain-complete pulse.
module systolic_skew_feeder #(
  parameter int DATA_W = 8,
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int PE_LAT = 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic                           in_last,
  input  logic [ROWS-1:0][DATA_W-1:0]    in_act,
  input  logic [COLS-1:0][DATA_W-1:0]    in_wgt,
  output logic [ROWS-1:0][DATA_W-1:0]    act_data,
  output logic [ROWS-1:0]                act_valid,
  output logic [COLS-1:0][DATA_W-1:0]    wgt_data,
  output logic [COLS-1:0]                wgt_valid,
  output logic                           counter_sync_out,
  output logic                           busy,
  output logic                           tile_done
);

  localparam int DRAIN_CNT = ROWS + COLS - 2 + PE_LAT;
  localparam int CNT_W     = (DRAIN_CNT < 1) ? 1 : $clog2(DRAIN_CNT + 1);

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             rdy_q;
  logic             sync_q;
  logic             accept;

  assign accept = in_valid && rdy_q;

  // in_ready is registered so it reads 0 while reset is held and rises on the first edge after release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
      sync_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= (state_d != DRAIN);
      sync_q  <= accept && (state_q == IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_last) begin
            state_d = DRAIN;
            cnt_d   = CNT_W'(DRAIN_CNT);
          end else begin
            state_d = STREAM;
          end
        end
      end
      STREAM: begin
        if (accept && in_last) begin
          state_d = DRAIN;
          cnt_d   = CNT_W'(DRAIN_CNT);
        end
      end
      DRAIN: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready         = rdy_q;
    busy             = (state_q != IDLE);
    tile_done        = (state_q == DRAIN) && (cnt_q == '0);
    counter_sync_out = sync_q;
  end

  // Each lane shifts every cycle; newest element enters at the bottom, lane output is the top stage.
  for (genvar gi = 0; gi < ROWS; gi++) begin : g_act
    localparam int LW = (gi + 1) * DATA_W;
    localparam int LV = gi + 1;
    logic [LW-1:0] d_q;
    logic [LV-1:0] v_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        d_q <= '0;
        v_q <= '0;
      end else begin
        d_q <= (d_q << DATA_W) | LW'(accept ? in_act[gi] : '0);
        v_q <= (v_q << 1) | LV'(accept);
      end
    end

    assign act_data[gi]  = d_q[LW-1 -: DATA_W];
    assign act_valid[gi] = v_q[LV-1];
  end

  for (genvar gj = 0; gj < COLS; gj++) begin : g_wgt
    localparam int LW = (gj + 1) * DATA_W;
    localparam int LV = gj + 1;
    logic [LW-1:0] d_q;
    logic [LV-1:0] v_q;

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        d_q <= '0;
        v_q <= '0;
      end else begin
        d_q <= (d_q << DATA_W) | LW'(accept ? in_wgt[gj] : '0);
        v_q <= (v_q << 1) | LV'(accept);
      end
    end

    assign wgt_data[gj]  = d_q[LW-1 -: DATA_W];
    assign wgt_valid[gj] = v_q[LV-1];
  end

endmodule

// File: tb/tb_systolic_skew_feeder.sv
// Bench for systolic_skew_feeder: a per-period expectation table is filled from each accepted
// beat (lane i sees it i periods later, tile framing from first/last beats) and compared every cycle.
module tb_systolic_skew_feeder;
  localparam int DATA_W = 8;
  localparam int ROWS   = 4;
  localparam int COLS   = 4;
  localparam int PE_LAT = 1;
  localparam int D      = ROWS + COLS - 2 + PE_LAT;
  localparam int N      = 2048;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic in_valid = 1'b0;
  logic in_last = 1'b0;
  logic in_ready;
  logic [ROWS-1:0][DATA_W-1:0] in_act = '0;
  logic [COLS-1:0][DATA_W-1:0] in_wgt = '0;
  logic [ROWS-1:0][DATA_W-1:0] act_data;
  logic [ROWS-1:0]             act_valid;
  logic [COLS-1:0][DATA_W-1:0] wgt_data;
  logic [COLS-1:0]             wgt_valid;
  logic counter_sync_out, busy, tile_done;

  always #5 clk = ~clk;

  systolic_skew_feeder #(.DATA_W(DATA_W), .ROWS(ROWS), .COLS(COLS), .PE_LAT(PE_LAT)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_act(in_act), .in_wgt(in_wgt), .act_data(act_data), .act_valid(act_valid),
    .wgt_data(wgt_data), .wgt_valid(wgt_valid), .counter_sync_out(counter_sync_out),
    .busy(busy), .tile_done(tile_done)
  );

  // Expected outputs per period; period p starts at posedge number p.
  logic [ROWS-1:0]             ex_av [N];
  logic [ROWS-1:0][DATA_W-1:0] ex_ad [N];
  logic [COLS-1:0]             ex_wv [N];
  logic [COLS-1:0][DATA_W-1:0] ex_wd [N];
  bit ex_sync [N];
  bit ex_busy [N];
  bit ex_done [N];
  bit ex_nrdy [N];

  logic [DATA_W-1:0] obs_a1 [N];
  logic [DATA_W-1:0] obs_a2 [N];
  logic [DATA_W-1:0] obs_w3 [N];
  logic obs_av0 [N];
  logic obs_av1 [N];
  logic obs_sync [N];
  logic obs_done [N];
  logic obs_rdy [N];

  int per;
  bit open;
  int checks;
  int errors;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s period=%0d observed=%0h expected=%0h", tag, per, obs, exp);
    end
  endtask

  task automatic clear_from(input int p);
    for (int q = p; q < N; q++) begin
      ex_av[q] = '0; ex_ad[q] = '0; ex_wv[q] = '0; ex_wd[q] = '0;
      ex_sync[q] = 0; ex_busy[q] = 0; ex_done[q] = 0; ex_nrdy[q] = 0;
    end
  endtask

  task automatic check_period();
    obs_a1[per] = act_data[1]; obs_a2[per] = act_data[2]; obs_w3[per] = wgt_data[3];
    obs_av0[per] = act_valid[0]; obs_av1[per] = act_valid[1];
    obs_sync[per] = counter_sync_out; obs_done[per] = tile_done; obs_rdy[per] = in_ready;
    chk("act_valid", 64'(act_valid), 64'(ex_av[per]));
    chk("act_data", 64'(act_data), 64'(ex_ad[per]));
    chk("wgt_valid", 64'(wgt_valid), 64'(ex_wv[per]));
    chk("wgt_data", 64'(wgt_data), 64'(ex_wd[per]));
    chk("counter_sync", 64'(counter_sync_out), 64'(ex_sync[per]));
    chk("busy", 64'(busy), 64'(ex_busy[per]));
    chk("tile_done", 64'(tile_done), 64'(ex_done[per]));
    chk("in_ready", 64'(in_ready), 64'(!ex_nrdy[per]));
  endtask

  task automatic step(input logic v, input logic l,
                      input logic [ROWS-1:0][DATA_W-1:0] a,
                      input logic [COLS-1:0][DATA_W-1:0] w);
    bit acc;
    check_period();
    in_valid = v; in_last = l; in_act = a; in_wgt = w;
    acc = v && !ex_nrdy[per];
    @(posedge clk);
    per++;
    if (acc) begin
      for (int i = 0; i < ROWS; i++) begin
        ex_av[per+i][i] = 1'b1;
        ex_ad[per+i][i] = a[i];
      end
      for (int j = 0; j < COLS; j++) begin
        ex_wv[per+j][j] = 1'b1;
        ex_wd[per+j][j] = w[j];
      end
      if (!open) begin
        ex_sync[per] = 1;
        open = 1;
      end
      if (l) begin
        for (int k = 0; k <= D; k++) begin
          ex_busy[per+k] = 1;
          ex_nrdy[per+k] = 1;
        end
        ex_done[per+D] = 1;
        open = 0;
      end
    end
    if (open) ex_busy[per] = 1;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'($urandom), $urandom, $urandom);
  endtask

  task automatic beat(input int k, input logic l);
    logic [ROWS-1:0][DATA_W-1:0] a;
    logic [COLS-1:0][DATA_W-1:0] w;
    for (int i = 0; i < ROWS; i++) a[i] = DATA_W'(10 * k + i);
    for (int j = 0; j < COLS; j++) w[j] = DATA_W'(20 * k + j);
    step(1'b1, l, a, w);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_act_valid"}, 64'(act_valid), 64'd0);
    chk({tag, "_wgt_valid"}, 64'(wgt_valid), 64'd0);
    chk({tag, "_act_data"}, 64'(act_data), 64'd0);
    chk({tag, "_wgt_data"}, 64'(wgt_data), 64'd0);
    chk({tag, "_ready"}, 64'(in_ready), 64'd0);
    chk({tag, "_busy"}, 64'(busy), 64'd0);
    chk({tag, "_sync"}, 64'(counter_sync_out), 64'd0);
    chk({tag, "_done"}, 64'(tile_done), 64'd0);
  endtask

  task automatic rst_seq(input int ncyc);
    reset_n = 1'b0; in_valid = 1'b1; in_last = 1'b0; in_act = $urandom; in_wgt = $urandom;
    #1;
    check_reset_outputs("rst_enter");
    clear_from(per);
    open = 0;
    repeat (ncyc) begin
      @(posedge clk); per++; @(negedge clk);
    end
    check_reset_outputs("rst_hold");
    reset_n = 1'b1; in_valid = 1'b0;
    ex_nrdy[per] = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog period=%0d observed=timeout expected=finish", per);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0;
    int cnt;
    per = 0; open = 0; checks = 0; errors = 0;
    clear_from(0);
    @(negedge clk);

    // Reset with in_valid held high
    rst_seq(3);
    idle(1);
    chk("ready_after_rst", 64'(in_ready), 64'd1);
    chk("busy_after_rst", 64'(busy), 64'd0);

    // Skew: three beats, last on k=2
    idle(2);
    e0 = per + 1;
    beat(0, 1'b0); beat(1, 1'b0); beat(2, 1'b1);
    idle(12);
    chk("skew_a2_k0", 64'(obs_a2[e0+2]), 64'd2);
    chk("skew_a2_k1", 64'(obs_a2[e0+3]), 64'd12);
    chk("skew_a2_k2", 64'(obs_a2[e0+4]), 64'd22);
    chk("skew_w3_k0", 64'(obs_w3[e0+3]), 64'd3);
    chk("skew_w3_k1", 64'(obs_w3[e0+4]), 64'd23);
    chk("skew_w3_k2", 64'(obs_w3[e0+5]), 64'd43);
    chk("skew_sync_first", 64'(obs_sync[e0]), 64'd1);
    chk("skew_sync_after", 64'(obs_sync[e0+1]), 64'd0);
    chk("skew_done_at", 64'(obs_done[e0+9]), 64'd1);
    chk("skew_done_before", 64'(obs_done[e0+8]), 64'd0);
    chk("skew_done_after", 64'(obs_done[e0+10]), 64'd0);

    // Bubble between beat0 and beat1
    e0 = per + 1;
    beat(0, 1'b0); idle(1); beat(1, 1'b1);
    idle(12);
    chk("bubble_av1_0", 64'(obs_av1[e0+1]), 64'd1);
    chk("bubble_av1_1", 64'(obs_av1[e0+2]), 64'd0);
    chk("bubble_av1_2", 64'(obs_av1[e0+3]), 64'd1);
    chk("bubble_data0", 64'(obs_a1[e0+2]), 64'd0);

    // K=1 tile followed by a back-to-back tile
    e0 = per + 1;
    beat(5, 1'b1);
    idle(8);
    beat(6, 1'b1);
    idle(10);
    cnt = 0;
    for (int p = e0; p < e0 + 8; p++) cnt += int'(obs_rdy[p]);
    chk("k1_ready_low_cycles", 64'(cnt), 64'd0);
    chk("k1_sync", 64'(obs_sync[e0]), 64'd1);
    chk("k1_done", 64'(obs_done[e0+7]), 64'd1);
    chk("k1_ready_back", 64'(obs_rdy[e0+8]), 64'd1);
    chk("k1_second_sync", 64'(obs_sync[e0+9]), 64'd1);
    chk("k1_second_done", 64'(obs_done[e0+16]), 64'd1);

    // DRAIN holds in_valid high with fresh data; no extra beats may enter
    e0 = per + 1;
    beat(1, 1'b0); beat(2, 1'b1);
    repeat (7) step(1'b1, 1'($urandom), $urandom, $urandom);
    idle(6);
    cnt = 0;
    for (int p = e0; p < e0 + 13; p++) cnt += int'(obs_av0[p]);
    chk("drain_ignore_av0", 64'(cnt), 64'd2);

    // Reset mid-tile, then a fresh tile
    e0 = per + 1;
    beat(3, 1'b0); beat(4, 1'b0);
    rst_seq(2);
    idle(12);
    cnt = 0;
    for (int p = e0; p < per; p++) cnt += int'(obs_done[p]);
    chk("midrst_no_done", 64'(cnt), 64'd0);
    e0 = per + 1;
    beat(7, 1'b0); beat(8, 1'b0); beat(9, 1'b1);
    idle(12);
    chk("midrst_fresh_sync", 64'(obs_sync[e0]), 64'd1);
    chk("midrst_fresh_done", 64'(obs_done[e0+9]), 64'd1);

    // Randomized traffic
    repeat (400) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 5) == 0), $urandom, $urandom);
    end
    idle(D + 4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
